// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: walks the weight RAM in im2col-GEMM order and
// assembles PE_COLS-lane weight vectors for the PE array.
module weight_fetch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 10,
  parameter int PE_COLS    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          conv_en,
  input  logic [ADDR_SIZE-1:0]          k_len,
  input  logic [CNT_W-1:0]              n_out,
  input  logic [CNT_W-1:0]              m_tiles,
  output logic [ADDR_SIZE-1:0]          weight_addr,
  output logic                          w_addr_vld,
  input  logic [DATA_WIDTH-1:0]         weight_data,
  output logic [PE_COLS*DATA_WIDTH-1:0] w_vec,
  output logic                          w_vec_valid,
  input  logic                          w_vec_ready,
  output logic                          w_vec_last,
  output logic                          w_busy,
  output logic                          w_done,
  output logic [2:0]                    dbg_state
);

  localparam int JW = (PE_COLS > 1) ? $clog2(PE_COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state;
  logic                 conv_q, conv_q2;
  logic [ADDR_SIZE-1:0] k_r, k_cnt, grp_row, nxt_row, ptr;
  logic [CNT_W-1:0]     n_r, m_r, g0, rep;
  logic [JW-1:0]        j, cap_j;
  logic                 cap_en, cap_zero;

  logic lane_ok, last_k, more_grp, more_rep, start, last_lane, zero_cfg;

  assign lane_ok   = ({1'b0, g0} + (CNT_W+1)'(j)) < {1'b0, n_r};
  assign last_k    = (k_cnt == k_r - ADDR_SIZE'(1));
  assign more_grp  = ({1'b0, g0} + (CNT_W+1)'(PE_COLS)) < {1'b0, n_r};
  assign more_rep  = ({1'b0, rep} + (CNT_W+1)'(1)) < {1'b0, m_r};
  assign start     = conv_q && !conv_q2 && (state == S_IDLE);
  assign last_lane = (j == JW'(PE_COLS - 1));
  assign zero_cfg  = (k_len == '0) || (n_out == '0) || (m_tiles == '0);

  assign w_addr_vld  = (state == S_FETCH) && lane_ok;
  assign weight_addr = w_addr_vld ? ptr : '0;
  // Busy stays high through the w_done cycle and drops on the one after.
  assign w_busy      = (state != S_IDLE) || w_done;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      conv_q      <= 1'b0;
      conv_q2     <= 1'b0;
      k_r         <= '0;
      n_r         <= '0;
      m_r         <= '0;
      k_cnt       <= '0;
      g0          <= '0;
      rep         <= '0;
      j           <= '0;
      grp_row     <= '0;
      nxt_row     <= '0;
      ptr         <= '0;
      cap_en      <= 1'b0;
      cap_j       <= '0;
      cap_zero    <= 1'b0;
      w_vec       <= '0;
      w_vec_valid <= 1'b0;
      w_vec_last  <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      conv_q   <= conv_en;
      conv_q2  <= conv_q;
      w_done   <= 1'b0;
      // Read data returns one cycle after issue; write it into its lane then.
      cap_en   <= (state == S_FETCH);
      cap_j    <= j;
      cap_zero <= !lane_ok;
      if (cap_en)
        w_vec[cap_j*DATA_WIDTH +: DATA_WIDTH] <= cap_zero ? '0 : weight_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            k_r     <= k_len;
            n_r     <= n_out;
            m_r     <= m_tiles;
            k_cnt   <= '0;
            g0      <= '0;
            rep     <= '0;
            j       <= '0;
            grp_row <= '0;
            ptr     <= '0;
            state   <= zero_cfg ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          ptr <= ptr + k_r;
          if (last_lane) begin
            j     <= '0;
            state <= S_CAPTURE;
            // At k==0 the pointer after the last lane is the next group's row.
            if (k_cnt == '0) nxt_row <= ptr + k_r;
          end else begin
            j <= j + JW'(1);
          end
        end
        S_CAPTURE: begin
          w_vec_valid <= 1'b1;
          w_vec_last  <= last_k;
          state       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_vec_ready) begin
            w_vec_valid <= 1'b0;
            w_vec_last  <= 1'b0;
            state       <= S_FETCH;
            if (!last_k) begin
              k_cnt <= k_cnt + ADDR_SIZE'(1);
              ptr   <= grp_row + k_cnt + ADDR_SIZE'(1);
            end else if (more_grp) begin
              k_cnt   <= '0;
              g0      <= g0 + CNT_W'(PE_COLS);
              grp_row <= nxt_row;
              ptr     <= nxt_row;
            end else if (more_rep) begin
              k_cnt   <= '0;
              g0      <= '0;
              rep     <= rep + CNT_W'(1);
              grp_row <= '0;
              ptr     <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          w_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: RAM[a]=a+1 model, expected-vector queue built
// from the layer's nested loop order, table-driven and random configurations.
module tb_weight_fetch_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int PC = 4;
  localparam int CW = 16;
  localparam int VW = PC*DW + 1;

  logic          clk, rstn, conv_en;
  logic [AW-1:0] k_len;
  logic [CW-1:0] n_out, m_tiles;
  logic [AW-1:0] weight_addr;
  logic          w_addr_vld;
  logic [DW-1:0] weight_data;
  logic [PC*DW-1:0] w_vec;
  logic          w_vec_valid, w_vec_ready, w_vec_last, w_busy, w_done;
  logic [2:0]    dbg_state;

  weight_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .PE_COLS(PC), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .conv_en(conv_en), .k_len(k_len), .n_out(n_out),
    .m_tiles(m_tiles), .weight_addr(weight_addr), .w_addr_vld(w_addr_vld),
    .weight_data(weight_data), .w_vec(w_vec), .w_vec_valid(w_vec_valid),
    .w_vec_ready(w_vec_ready), .w_vec_last(w_vec_last), .w_busy(w_busy),
    .w_done(w_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_cnt, done_cnt, av_cnt, exp_av;
  int ready_mode = 0;  // 0: high, 1: random, 2: manual
  logic [VW-1:0] exp_q[$];

  // RAM model: registered read, RAM[a] = a+1
  always @(posedge clk)
    weight_data <= w_addr_vld ? DW'({6'b0, weight_addr} + 16'd1) : 16'hDEAD;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) w_vec_ready = 1'b1;
    else if (ready_mode == 1) w_vec_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (w_done) done_cnt++;
      if (w_addr_vld) av_cnt++;
      if (w_vec_valid) begin
        checks++;
        if (w_addr_vld) begin
          errors++;
          $display("FAIL no_read_in_present: w_addr_vld=%0b required 0", w_addr_vld);
        end
      end
      if (w_vec_valid && w_vec_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vec_extra: got last=%0b vec=%h, none expected", w_vec_last, w_vec);
        end else begin
          logic [VW-1:0] e;
          e = exp_q.pop_front();
          if ({w_vec_last, w_vec} !== e) begin
            errors++;
            $display("FAIL vec_data: got last=%0b vec=%h required last=%0b vec=%h",
                     w_vec_last, w_vec, e[VW-1], e[VW-2:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // reference: vectors in (rep, group, k) order, lane j = filter g+j
  task automatic build_model(input int k, input int n, input int m);
    exp_q.delete();
    exp_av = 0;
    if (k == 0 || n == 0 || m == 0) return;
    for (int r = 0; r < m; r++)
      for (int g = 0; g < n; g += PC)
        for (int kk = 0; kk < k; kk++) begin
          logic [VW-1:0] v;
          v = '0;
          for (int jj = 0; jj < PC; jj++)
            if (g + jj < n) begin
              v[jj*DW +: DW] = DW'((((g + jj) * k + kk) % 1024) + 1);
              exp_av++;
            end
          v[VW-1] = (kk == k - 1);
          exp_q.push_back(v);
        end
  endtask

  // driver: one full run; lat_v/lat_d are cycles from the sampling edge
  task automatic run_cfg(input int k, input int n, input int m, input int exp_vecs,
                         input int mode, input bit mid_rise,
                         output int lat_v, output int lat_d);
    int cyc;
    bit held;
    logic [VW:0] snap;
    build_model(k, n, m);
    hs_cnt = 0; done_cnt = 0; av_cnt = 0;
    lat_v = -1; lat_d = -1; held = 0;
    ready_mode = mode;
    if (mode == 2) w_vec_ready = 1'b0;
    @(posedge clk); #1;
    k_len = AW'(k); n_out = CW'(n); m_tiles = CW'(m);
    conv_en = 1'b1;
    cyc = 0;
    while (lat_d < 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (w_vec_valid && lat_v < 0) lat_v = cyc - 1;
      if (w_done && lat_d < 0) lat_d = cyc - 1;
      if (cyc == 3) conv_en = 1'b0;
      if (cyc == 5) begin
        k_len = AW'($urandom_range(0, 7)); n_out = CW'($urandom_range(0, 9));
        m_tiles = CW'($urandom_range(0, 3));
      end
      if (mid_rise && cyc == 9) conv_en = 1'b1;
      if (mid_rise && cyc == 12) conv_en = 1'b0;
      if (mode == 2 && w_vec_valid && !held) begin
        held = 1;
        snap = {w_vec_valid, w_vec_last, w_vec};
        repeat (5) begin
          @(posedge clk); #1;
          cyc++;
          check("hold_stable", ({w_vec_valid, w_vec_last, w_vec} == snap), 1);
          check("hold_no_read", w_addr_vld, 0);
        end
        w_vec_ready = 1'b1;
        ready_mode = 0;
      end
    end
    if (lat_d < 0) begin
      errors++; checks++;
      $display("FAIL done_timeout: w_done not seen in %0d cycles", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("vec_count", hs_cnt, exp_vecs);
    check("vec_leftover", exp_q.size(), 0);
    check("read_count", av_cnt, exp_av);
    check("idle_after", w_busy, 0);
    ready_mode = 0;
  endtask

  typedef struct {
    int k; int n; int m; int exp_vecs; int mode;
  } vec_t;

  vec_t tbl[6];
  int lv, ld;

  initial begin
    tbl[0] = '{k: 3, n: 4, m: 1, exp_vecs: 3,  mode: 1};
    tbl[1] = '{k: 2, n: 5, m: 1, exp_vecs: 4,  mode: 0};
    tbl[2] = '{k: 3, n: 4, m: 2, exp_vecs: 6,  mode: 0};
    tbl[3] = '{k: 1, n: 1, m: 1, exp_vecs: 1,  mode: 1};
    tbl[4] = '{k: 5, n: 9, m: 1, exp_vecs: 15, mode: 1};
    tbl[5] = '{k: 4, n: 8, m: 3, exp_vecs: 24, mode: 1};

    rstn = 1'b0; conv_en = 1'b0; w_vec_ready = 1'b1;
    k_len = '0; n_out = '0; m_tiles = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {w_addr_vld, w_vec_valid, w_vec_last, w_busy, w_done}, 0);
    check("rst_vec", (w_vec == '0 && weight_addr == '0), 1);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // scenario 1 with latency checks
    run_cfg(3, 4, 1, 3, 0, 0, lv, ld);
    check("first_valid_latency", lv, PC + 2);

    // zero configurations
    run_cfg(0, 4, 1, 0, 0, 0, lv, ld);
    check("zero_k_done_latency", ld, 2);
    check("zero_k_no_valid", lv, -1);
    run_cfg(3, 0, 1, 0, 0, 0, lv, ld);
    run_cfg(3, 4, 0, 0, 0, 0, lv, ld);

    // backpressure
    run_cfg(3, 4, 1, 3, 2, 0, lv, ld);

    // table
    for (int i = 0; i < 6; i++)
      run_cfg(tbl[i].k, tbl[i].n, tbl[i].m, tbl[i].exp_vecs, tbl[i].mode, 0, lv, ld);

    // random configurations
    for (int i = 0; i < 8; i++) begin
      int k, n, m;
      k = $urandom_range(1, 5);
      n = $urandom_range(1, 10);
      m = $urandom_range(1, 2);
      run_cfg(k, n, m, m * ((n + PC - 1) / PC) * k, 1, 0, lv, ld);
    end

    // reset in the middle of FETCH
    begin
      int cyc;
      done_cnt = 0;
      @(posedge clk); #1;
      k_len = 10'd3; n_out = 16'd4; m_tiles = 16'd1; conv_en = 1'b1;
      cyc = 0;
      while (!w_addr_vld && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("reached_fetch", w_addr_vld, 1);
      rstn = 1'b0;
      #1;
      check("midrst_outputs", {w_addr_vld, w_vec_valid, w_vec_last, w_busy, w_done}, 0);
      check("midrst_vec", (w_vec == '0 && weight_addr == '0), 1);
      conv_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt, 0);
      exp_q.delete();
    end

    // clean run after reset, with an ignored conv_en rise mid-run
    run_cfg(3, 4, 1, 3, 0, 1, lv, ld);
    check("post_rst_latency", lv, PC + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Downstream consumer of the weight buffer. It walks the weight RAM in im2col-GEMM order and drives `weight_addr`/`w_addr_vld`.
- It captures `weight_data` into a PE_COLS-wide weight vector for the PE array, handshaked with valid/ready.
- When every vector for the layer has been delivered, it pulses `w_done`, which re-arms the weight buffer for the next DMA load.
- Weight layout in RAM: filter n, reduction element k, at address n*k_len + k.

Parameters:
- DATA_WIDTH, 16: width of one weight word; must equal the buffer data width.
- ADDR_SIZE, 10: weight RAM address width.
- PE_COLS, 4: number of filters per output vector (lanes).
- CNT_W, 16: width of the n_out and m_tiles counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- conv_en  in  1  run request; a rising edge while IDLE starts a run
- k_len  in  ADDR_SIZE  reduction length K (C*kh*kw)
- n_out  in  CNT_W  number of filters
- m_tiles  in  CNT_W  number of times the full weight sequence is replayed
- weight_addr  out  ADDR_SIZE  RAM read address
- w_addr_vld  out  1  read enable
- weight_data  in  DATA_WIDTH  RAM read data, valid one cycle after the read is issued
- w_vec  out  PE_COLS*DATA_WIDTH  weight vector; lane j occupies [j*DATA_WIDTH +: DATA_WIDTH]
- w_vec_valid  out  1  w_vec is valid
- w_vec_ready  in  1  PE array accepts the vector
- w_vec_last  out  1  marks the last k of the current filter group
- w_busy  out  1  high whenever the block is not IDLE
- w_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; conv_en edge detector cleared.
- Start:
  - conv_en is registered for edge detection; a 0→1 seen in IDLE latches k_len, n_out and m_tiles.
  - Config input changes after the start are ignored until the run completes.
  - conv_en edges outside IDLE are ignored.
- Zero config: if k_len==0, n_out==0 or m_tiles==0, go IDLE→DONE. w_done pulses; no reads, no vectors.
- Counters:
  - k in 0..K-1.
  - group base g0 steps by PE_COLS.
  - rep in 0..m_tiles-1.
  - lane index j.
- Address generation uses no multiplier. A running pointer starts at g0*K+k (kept as a grp_row register that advances by PE_COLS*K per group) and adds K per lane. Addresses truncate to ADDR_SIZE.
- FETCH, PE_COLS cycles, lane j per cycle:
  - If g0+j < n_out: `w_addr_vld`=1, `weight_addr`=ptr.
  - Otherwise: `w_addr_vld`=0 and the lane is zero-padded.
- Capture: data from the lane-j read is written into lane j on the following cycle. CAPTURE is one extra cycle after the last issue; the block then enters PRESENT.
- PRESENT:
  - `w_vec_valid`=1; `w_vec_last`=(k==K-1).
  - w_vec, w_vec_valid and w_vec_last stay stable until w_vec_ready.
  - No RAM reads occur in PRESENT.
- On handshake (valid&&ready):
  - If k<K-1: k++.
  - Else if g0+PE_COLS<n_out: k=0 and move to the next group.
  - Else if rep<m_tiles-1: k=0, g0=0, rep++.
  - Else: DONE.
  - Except for DONE, the next state is FETCH.
- Timing:
  - Cycles per vector: PE_COLS+2 minimum (PE_COLS FETCH + 1 CAPTURE + 1 PRESENT with ready high).
  - First w_vec_valid is high PE_COLS+2 cycles after the edge that samples the conv_en rise.
- DONE: w_done=1 for exactly one cycle, w_busy=0 on the following cycle, state returns to IDLE.
- w_vec_valid is 0 outside PRESENT. w_addr_vld is 0 outside FETCH.
- Reset mid-run aborts immediately: all outputs 0, no w_done.
- Vector count per run: m_tiles*ceil(n_out/PE_COLS)*K.

Test Plan:
- PE_COLS=4, RAM[a]=a+1, K=3, n_out=4, m_tiles=1, ready tied high → 3 vectors.
  - Lanes {1,4,7,10}, {2,5,8,11}, {3,6,9,12}.
  - w_vec_last only on the third vector.
  - First valid PE_COLS+2=6 cycles after the start edge.
  - w_done single pulse after the third handshake.
- K=2, n_out=5 → 4 vectors.
  - Second group lanes {9,0,0,0} then {10,0,0,0}.
  - In the second group, w_addr_vld is high for only one FETCH cycle per vector.
- Backpressure: ready low for 5 cycles during PRESENT → w_vec and w_vec_last held stable, w_addr_vld 0 throughout, and no vector lost or duplicated.
- m_tiles=2, K=3, n_out=4 → 6 vectors, with the 3-vector sequence repeated identically; one w_done.
- k_len=0 → w_done pulses 2 cycles after the start edge; no w_addr_vld, no w_vec_valid.
- rstn low mid-FETCH → all outputs 0 at once.
  - A new conv_en rise then gives a clean run matching scenario 1.
  - A conv_en rise issued during a run is ignored.
